scan_cycle_sequencer: RTL and testbench

Controller that sequences one PLC scan cycle: latch inputs, restart the EEPROM program fetch, gate instruction execution, commit outputs. It replaces the ad-hoc auto-restart and scan-trigger wiring between the EEPROM reader and the executor. Scans start from a periodic auto tick or an external trigger pin. A watchdog aborts runaway programs and sticky flags report overruns.

---
 rtl/scan_cycle_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_scan_cycle_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// scan_cycle_sequencer
// Sequences one PLC scan: latch inputs, restart the EEPROM fetch, gate
// instruction execution, then commit outputs. Scans are started by a periodic
// auto tick or by an external (asynchronous) trigger pin. A watchdog aborts
// runaway programs, and sticky flags report overruns and watchdog aborts.
//
// Ports:
//   clk, rst_n     clock (rising edge) and async active-low reset
//   auto_en        enable periodic auto scans
//   scan_period    clocks between auto ticks; 0 = continuous mode
//   trig_in        raw external scan trigger, asynchronous to clk
//   prog_end       one-cycle pulse: last program instruction executed
//   wdt_limit      max clocks allowed in EXEC; 0 disables the watchdog
//   clear_faults   clears overrun and wdt_fault
//   latch_inputs   one-cycle pulse: capture ui_in
//   restart_read   one-cycle pulse to the EEPROM reader
//   exec_en        high while the executor may run
//   commit         one-cycle pulse: copy output shadow to pins
//   busy           high in any state other than IDLE
//   overrun        sticky: scan request arrived while busy
//   wdt_fault      sticky: watchdog abort occurred
//   scan_count     committed scans, wraps 255 -> 0
// -----------------------------------------------------------------------------
module scan_cycle_sequencer #(
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned WDT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                auto_en,
  input  logic [PERIOD_W-1:0] scan_period,
  input  logic                trig_in,
  input  logic                prog_end,
  input  logic [WDT_W-1:0]    wdt_limit,
  input  logic                clear_faults,
  output logic                latch_inputs,
  output logic                restart_read,
  output logic                exec_en,
  output logic                commit,
  output logic                busy,
  output logic                overrun,
  output logic                wdt_fault,
  output logic [7:0]          scan_count
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_START  = 3'd2,
    ST_EXEC   = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_s1;
  logic                r_s2;
  logic                r_s3;
  logic [PERIOD_W-1:0] r_period_cnt;
  logic [WDT_W-1:0]    r_wdt_cnt;
  logic                r_pending;
  logic                r_overrun;
  logic                r_wdt_fault;
  logic [CNT_W-1:0]    r_scan_count;

  logic                w_trig_edge;
  logic                w_auto_tick;
  logic                w_req;
  logic                w_busy;
  logic                w_wdt_expire;
  logic                w_period_zero;
  logic [PERIOD_W-1:0] w_reload;

  // Trigger synchronizer and rising-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= trig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_trig_edge   = r_s2 & ~r_s3;
  assign w_period_zero = (scan_period == '0);
  assign w_auto_tick   = auto_en & (r_period_cnt == '0);
  assign w_req         = w_trig_edge | w_auto_tick | r_pending;
  assign w_busy        = (r_state != ST_IDLE);
  assign w_wdt_expire  = (wdt_limit != '0) && (r_wdt_cnt == (wdt_limit - WDT_W'(1)));

  // Reloading with period-1 makes consecutive ticks exactly scan_period
  // clocks apart; a zero period keeps the counter at 0 (tick every cycle).
  assign w_reload = w_period_zero ? '0 : (scan_period - PERIOD_W'(1));

  // Auto tick period counter; parked at 0 while disabled so enable ticks at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period_cnt <= '0;
    end else if (!auto_en) begin
      r_period_cnt <= '0;
    end else if (w_auto_tick) begin
      r_period_cnt <= w_reload;
    end else begin
      r_period_cnt <= r_period_cnt - PERIOD_W'(1);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; prog_end has priority over watchdog expiry
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (w_req) w_state_nxt = ST_LATCH;
      ST_LATCH:  w_state_nxt = ST_START;
      ST_START:  w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (prog_end) begin
          w_state_nxt = ST_COMMIT;
        end else if (w_wdt_expire) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    latch_inputs = 1'b0;
    restart_read = 1'b0;
    exec_en      = 1'b0;
    commit       = 1'b0;
    unique case (r_state)
      ST_LATCH:  latch_inputs = 1'b1;
      ST_START:  restart_read = 1'b1;
      ST_EXEC:   exec_en      = 1'b1;
      ST_COMMIT: commit       = 1'b1;
      default:   ;
    endcase
  end

  // Watchdog counter: cleared when a scan starts, saturating during EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdt_cnt <= '0;
    end else if (r_state == ST_START) begin
      r_wdt_cnt <= '0;
    end else if ((r_state == ST_EXEC) && (r_wdt_cnt != '1)) begin
      r_wdt_cnt <= r_wdt_cnt + WDT_W'(1);
    end
  end

  // Single-entry pending request; consumed whenever the FSM sits in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
    end else if (!w_busy) begin
      r_pending <= 1'b0;
    end else if (w_trig_edge | w_auto_tick) begin
      r_pending <= 1'b1;
    end
  end

  // Sticky fault flags; a set event beats clear_faults in the same cycle.
  // Continuous-mode ticks while busy are expected and do not flag overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun   <= 1'b0;
      r_wdt_fault <= 1'b0;
    end else begin
      if (w_busy && (w_trig_edge || (w_auto_tick && !w_period_zero))) begin
        r_overrun <= 1'b1;
      end else if (clear_faults) begin
        r_overrun <= 1'b0;
      end
      if ((r_state == ST_EXEC) && !prog_end && w_wdt_expire) begin
        r_wdt_fault <= 1'b1;
      end else if (clear_faults) begin
        r_wdt_fault <= 1'b0;
      end
    end
  end

  // Completed scan counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_count <= '0;
    end else if (r_state == ST_COMMIT) begin
      r_scan_count <= r_scan_count + CNT_W'(1);
    end
  end

  assign busy       = w_busy;
  assign overrun    = r_overrun;
  assign wdt_fault  = r_wdt_fault;
  assign scan_count = r_scan_count;

endmodule

// File: tb/tb_scan_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_scan_cycle_sequencer
// Self-checking bench: directed scenarios plus a randomized run, compared
// every cycle against a transaction-level reference model (scan age counter,
// timestamp-based auto ticks, trigger sample history).
// -----------------------------------------------------------------------------
module tb_scan_cycle_sequencer;

  localparam int unsigned PW = 16;
  localparam int unsigned WW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          auto_en;
  logic [PW-1:0] scan_period;
  logic          trig_in;
  logic          prog_end;
  logic [WW-1:0] wdt_limit;
  logic          clear_faults;
  logic          latch_inputs;
  logic          restart_read;
  logic          exec_en;
  logic          commit;
  logic          busy;
  logic          overrun;
  logic          wdt_fault;
  logic [7:0]    scan_count;

  always #5 clk = ~clk;

  scan_cycle_sequencer #(.PERIOD_W(PW), .WDT_W(WW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .auto_en      (auto_en),
    .scan_period  (scan_period),
    .trig_in      (trig_in),
    .prog_end     (prog_end),
    .wdt_limit    (wdt_limit),
    .clear_faults (clear_faults),
    .latch_inputs (latch_inputs),
    .restart_read (restart_read),
    .exec_en      (exec_en),
    .commit       (commit),
    .busy         (busy),
    .overrun      (overrun),
    .wdt_fault    (wdt_fault),
    .scan_count   (scan_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_age: -1 when idle, otherwise cycles since the scan's latch cycle.
  int m_age;
  bit m_commit, m_pend, m_ovr, m_wdt;
  int m_cnt;
  bit h0, h1, h2;       // trig_in sampled at the last three edges (newest first)
  int m_cyc, m_next_tick;
  int pe_at;            // >0: prog_end on that EXEC cycle, 0: never, <0: random

  task automatic model_reset();
    m_age = -1; m_commit = 0; m_pend = 0; m_ovr = 0; m_wdt = 0; m_cnt = 0;
    h0 = 0; h1 = 0; h2 = 0; m_cyc = 0; m_next_tick = 0;
  endtask

  function automatic logic [6:0] m_outs();
    logic in_exec;
    in_exec = (m_age >= 2) && !m_commit;
    return {m_age >= 0, m_age == 0, m_age == 1, in_exec, m_commit, m_ovr, m_wdt};
  endfunction

  task automatic model_step();
    bit t_edge, tick, req, ovr_set, wdt_set;
    int per;
    t_edge  = h1 & ~h2;
    per     = int'(scan_period);
    tick    = 0;
    ovr_set = 0;
    wdt_set = 0;
    if (auto_en) begin
      if (m_cyc >= m_next_tick) begin
        tick = 1;
        m_next_tick = m_cyc + ((per == 0) ? 1 : per);
      end
    end else begin
      m_next_tick = m_cyc + 1;
    end
    req = t_edge | tick | m_pend;
    if (m_age < 0) begin
      m_pend = 0;
      if (req) m_age = 0;
    end else begin
      if (t_edge || tick) begin
        m_pend = 1;
        if (t_edge || (tick && per != 0)) ovr_set = 1;
      end
      if (m_commit) begin
        m_commit = 0;
        m_age = -1;
        m_cnt = (m_cnt + 1) % 256;
      end else if (m_age >= 2) begin
        if (prog_end) m_commit = 1;
        else if (wdt_limit != 0 && (m_age - 1) == int'(wdt_limit)) begin
          wdt_set = 1;
          m_age = -1;
        end else m_age++;
      end else begin
        m_age++;
      end
    end
    if (ovr_set) m_ovr = 1; else if (clear_faults) m_ovr = 0;
    if (wdt_set) m_wdt = 1; else if (clear_faults) m_wdt = 0;
    h2 = h1; h1 = h0; h0 = trig_in;
    m_cyc++;
  endtask

  // ---------------- observed-output statistics ----------------
  int tb_cyc;
  int st_busy, st_latch, st_exec, st_commit, st_gap;
  int st_latch_at, st_restart_at, st_commit_at;

  task automatic clr_stats();
    st_busy = 0; st_latch = 0; st_exec = 0; st_commit = 0; st_gap = 0;
    st_latch_at = 0; st_restart_at = 0; st_commit_at = 0;
  endtask

  // One clock: drive prog_end, advance model, compare after the edge.
  task automatic tick_cycle();
    bit in_exec;
    in_exec = (m_age >= 2) && !m_commit;
    if (pe_at > 0)      prog_end = in_exec && ((m_age - 1) == pe_at);
    else if (pe_at < 0) prog_end = in_exec && ($urandom_range(5) == 0);
    else                prog_end = 1'b0;
    model_step();
    @(negedge clk);
    check("outs", {busy, latch_inputs, restart_read, exec_en, commit, overrun, wdt_fault}, m_outs());
    check("scan_count", scan_count, m_cnt);
    tb_cyc++;
    if (busy) st_busy++;
    if (exec_en) st_exec++;
    if (restart_read) st_restart_at = tb_cyc;
    if (commit) begin st_commit++; st_commit_at = tb_cyc; end
    if (latch_inputs) begin
      st_gap = tb_cyc - st_latch_at;
      st_latch++;
      st_latch_at = tb_cyc;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_outs", {busy, latch_inputs, restart_read, exec_en, commit, overrun, wdt_fault}, 7'd0);
    check("rst_count", scan_count, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic trig_pulse(input int hi, input int lo);
    trig_in = 1'b1;
    repeat (hi) tick_cycle();
    trig_in = 1'b0;
    repeat (lo) tick_cycle();
  endtask

  initial begin
    rst_n = 1'b0; auto_en = 0; scan_period = '0; trig_in = 0; prog_end = 0;
    wdt_limit = '0; clear_faults = 0; pe_at = 0; tb_cyc = 0;
    clr_stats();
    model_reset();
    do_reset();

    // single triggered scan, prog_end on EXEC cycle 10
    clr_stats(); pe_at = 10;
    trig_pulse(3, 30);
    check("p2_busy_cycles", st_busy, 13);
    check("p2_latch_n", st_latch, 1);
    check("p2_restart_gap", st_restart_at - st_latch_at, 1);
    check("p2_commit_gap", st_commit_at - st_latch_at, 12);
    check("p2_count", scan_count, 1);

    // periodic scans, 256 of them to wrap the counter
    do_reset();
    clr_stats(); pe_at = 5; scan_period = PW'(50); auto_en = 1;
    repeat (12790) begin
      tick_cycle();
      if (latch_inputs && st_latch > 1) check("p3_period", st_gap, 50);
    end
    auto_en = 0;
    repeat (15) tick_cycle();
    check("p3_latch_n", st_latch, 256);
    check("p3_wrap", scan_count, 0);
    check("p3_overrun", overrun, 0);

    // watchdog abort at 20 EXEC cycles
    clr_stats(); pe_at = 0; wdt_limit = WW'(20);
    trig_pulse(2, 40);
    check("p4_exec_cycles", st_exec, 20);
    check("p4_wdt_fault", wdt_fault, 1);
    check("p4_commit_n", st_commit, 0);
    check("p4_count", scan_count, 0);
    clear_faults = 1; tick_cycle(); clear_faults = 0; tick_cycle();
    check("p4_wdt_cleared", wdt_fault, 0);

    // two trigger edges during one scan -> one extra scan
    clr_stats(); wdt_limit = '0; pe_at = 15;
    trig_pulse(2, 6);
    trig_pulse(2, 2);
    trig_pulse(2, 60);
    check("p5_latch_n", st_latch, 2);
    check("p5_overrun", overrun, 1);
    clear_faults = 1; tick_cycle(); clear_faults = 0;

    // continuous mode: back-to-back scans with one idle cycle
    clr_stats(); pe_at = 3; scan_period = '0; auto_en = 1;
    repeat (60) begin
      tick_cycle();
      if (latch_inputs && st_latch > 1) check("p6_gap", st_gap, 7);
    end
    auto_en = 0;
    repeat (20) tick_cycle();
    check("p6_overrun", overrun, 0);

    // prog_end and watchdog expiry on the same cycle
    clr_stats(); wdt_limit = WW'(5); pe_at = 5;
    trig_pulse(2, 20);
    check("p6_same_commit", st_commit, 1);
    check("p6_same_wdt", wdt_fault, 0);

    // randomized run
    do_reset();
    pe_at = -1;
    repeat (3000) begin
      if ($urandom_range(4) == 0)   trig_in = ~trig_in;
      if ($urandom_range(99) == 0)  auto_en = ~auto_en;
      if ($urandom_range(49) == 0)  scan_period = PW'($urandom_range(20));
      if ($urandom_range(199) == 0) wdt_limit = WW'($urandom_range(15));
      clear_faults = ($urandom_range(29) == 0);
      tick_cycle();
    end
    auto_en = 0; trig_in = 0; clear_faults = 0;
    repeat (30) tick_cycle();

    // reset asserted mid-EXEC, trigger held high across reset release
    wdt_limit = '0; pe_at = 0;
    trig_in = 1;
    repeat (3) tick_cycle();
    trig_in = 0;
    for (int i = 0; i < 10 && !exec_en; i++) tick_cycle();
    check("p8_in_exec", exec_en, 1);
    trig_in = 1;
    do_reset();
    clr_stats(); pe_at = 4;
    repeat (30) tick_cycle();
    check("p8_held_trig_scans", st_latch, 1);
    trig_in = 0;
    repeat (5) tick_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
